// File: rtl/pp_pipeline_accel_fifo_wr_arb.sv
// ============================================================================
// Module  : pp_pipeline_accel_fifo_wr_arb
// Brief   : Packet-atomic round-robin arbiter sharing one stream-FIFO write
//           port among NUM_REQ producers. Optional per-grant beat limit is
//           enabled by defining PP_ARB_BURST_LIMIT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pp_pipeline_accel_fifo_wr_arb #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int MAX_BURST  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_write,
  output logic [DATA_WIDTH-1:0]         fifo_din,
  input  logic                          fifo_full_n,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
);

  localparam int c_gw = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("NUM_REQ must be in 2..8");
  end
  if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_max_burst
    $error("MAX_BURST must be in 1..255");
  end

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [c_gw-1:0]   r_grant;
  logic [c_gw-1:0]   w_grant_nxt;
  logic [c_gw-1:0]   r_rr_ptr;
  logic [c_gw-1:0]   w_rr_nxt;
  logic [c_gw-1:0]   w_winner;
  logic              w_found;
  logic              w_beat;
  logic              w_limit_hit;
  logic              w_burst_done;
  logic [DATA_WIDTH-1:0] w_data [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_data[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  // Scan from farthest to nearest so the candidate right after rr_ptr wins.
  always_comb begin
    logic [c_gw-1:0] v_idx;
    w_found  = 1'b0;
    w_winner = '0;
    v_idx    = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      v_idx = c_gw'((int'(r_rr_ptr) + k) % NUM_REQ);
      if (req_valid[v_idx]) begin
        w_found  = 1'b1;
        w_winner = v_idx;
      end
    end
  end

  assign busy       = (r_state == ST_BURST);
  assign grant_id   = r_grant;
  assign fifo_write = busy & req_valid[r_grant] & fifo_full_n;
  assign req_ready  = (busy & fifo_full_n) ? (NUM_REQ'(1) << r_grant) : '0;
  assign fifo_din   = w_data[r_grant];
  assign w_beat     = fifo_write;

`ifdef PP_ARB_BURST_LIMIT_EN
  localparam int c_cw = $clog2(MAX_BURST + 1);

  logic [c_cw-1:0] r_beat_cnt;
  logic [c_cw-1:0] w_cnt_nxt;

  // The counter holds beats already written, so the limit beat is MAX_BURST-1.
  assign w_limit_hit = (r_beat_cnt == c_cw'(MAX_BURST - 1));

  always_comb begin
    w_cnt_nxt = r_beat_cnt;
    if (w_burst_done) begin
      w_cnt_nxt = '0;
    end else if (w_beat) begin
      w_cnt_nxt = r_beat_cnt + c_cw'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_beat_cnt <= '0;
    end else begin
      r_beat_cnt <= w_cnt_nxt;
    end
  end
`else
  assign w_limit_hit = 1'b0;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_rr_nxt     = r_rr_ptr;
    w_burst_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_grant_nxt = w_winner;
          w_state_nxt = ST_BURST;
        end
      end
      ST_BURST: begin
        if (w_beat && (req_last[r_grant] || w_limit_hit)) begin
          w_state_nxt  = ST_IDLE;
          w_rr_nxt     = r_grant;
          w_burst_done = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_grant  <= '0;
      r_rr_ptr <= c_gw'(NUM_REQ - 1);
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_rr_ptr <= w_rr_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pp_pipeline_accel_fifo_wr_arb.sv
// ============================================================================
// Module  : tb_pp_pipeline_accel_fifo_wr_arb
// Brief   : Self-checking bench for the FIFO write arbiter (vector table,
//           directed corner sequences, randomized traffic vs. reference model).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pp_pipeline_accel_fifo_wr_arb;

  localparam int NR = 4;
  localparam int DW = 64;
  localparam int MB = 4;
`ifdef PP_ARB_BURST_LIMIT_EN
  localparam int C_LIMIT = MB;
`else
  localparam int C_LIMIT = 0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [NR-1:0]    req_valid = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR-1:0]    req_last = '0;
  logic [NR-1:0]    req_ready;
  logic             fifo_write;
  logic [DW-1:0]    fifo_din;
  logic             fifo_full_n = 1'b1;
  logic [1:0]       grant_id;
  logic             busy;

  pp_pipeline_accel_fifo_wr_arb #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .fifo_write(fifo_write),
    .fifo_din(fifo_din), .fifo_full_n(fifo_full_n), .grant_id(grant_id),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: owner flag, owner id, last-served id, beats this grant.
  logic m_on = 1'b0;
  logic m_busy = 1'b0;
  int   m_grant = 0;
  int   m_rr = NR - 1;
  int   m_cnt = 0;

  logic        s_busy, s_write;
  logic [1:0]  s_grant;
  logic [3:0]  s_ready;
  logic [63:0] s_din;
  logic [63:0] wlog[$];
  logic [63:0] expq[$];

  int p_act[NR], p_left[NR], p_len[NR], p_fix[NR], p_idx[NR], p_pkt[NR];

  function automatic logic [63:0] bw(input int i, input int pk, input int b);
    return {8'(i), 24'(pk), 32'(b)};
  endfunction

  function automatic logic [63:0] tword(input int i);
    return {8'hA5, 8'(i), 48'h0123_4567_89AB};
  endfunction

  task automatic setup(input int i, input int npk, input int len);
    p_act[i]  = (npk != 0) ? 1 : 0;
    p_left[i] = npk;
    p_fix[i]  = len;
    p_len[i]  = (len > 0) ? len : int'($urandom_range(1, 6));
    p_idx[i]  = 0;
    p_pkt[i]  = 0;
  endtask

  task automatic pop(input int i);
    p_idx[i]++;
    if (p_idx[i] == p_len[i]) begin
      p_idx[i] = 0;
      p_pkt[i]++;
      if (p_left[i] > 0) begin
        p_left[i]--;
        if (p_left[i] == 0) p_act[i] = 0;
      end
      p_len[i] = (p_fix[i] > 0) ? p_fix[i] : int'($urandom_range(1, 6));
    end
  endtask

  // One cycle: drive at negedge, sample 1ns later, advance model on posedge.
  task automatic step(input logic r, input logic [3:0] v, input logic [3:0] l,
                      input logic fn, output logic [3:0] acc);
    logic        e_write;
    logic [3:0]  e_ready;
    logic [63:0] e_din;
    logic        found;
    reset = r; req_valid = v; req_last = l; fifo_full_n = fn;
    #1;
    s_busy = busy; s_grant = grant_id; s_ready = req_ready;
    s_write = fifo_write; s_din = fifo_din;
    acc = req_valid & req_ready;
    e_ready = (m_busy && fn) ? (4'b0001 << m_grant) : 4'b0000;
    e_write = m_busy && v[m_grant] && fn;
    e_din   = req_data[m_grant*DW +: DW];
    if (m_on) begin
      chk("model_busy",  64'(s_busy),  64'(m_busy));
      chk("model_grant", 64'(s_grant), 64'(m_grant));
      chk("model_ready", 64'(s_ready), 64'(e_ready));
      chk("model_write", 64'(s_write), 64'(e_write));
      if (e_write) chk("model_din", s_din, e_din);
    end
    if (!r && s_write) wlog.push_back(s_din);
    @(posedge clk);
    if (r) begin
      m_busy = 1'b0; m_grant = 0; m_rr = NR - 1; m_cnt = 0;
    end else if (!m_busy) begin
      found = 1'b0;
      for (int k = 1; k <= NR; k++) begin
        if (!found && v[(m_rr + k) % NR]) begin
          found = 1'b1; m_grant = (m_rr + k) % NR; m_busy = 1'b1;
        end
      end
    end else if (e_write) begin
      m_cnt++;
      if (l[m_grant] || (C_LIMIT != 0 && m_cnt == C_LIMIT)) begin
        m_busy = 1'b0; m_rr = m_grant; m_cnt = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic pstep(input logic r, input logic [3:0] en, input logic fn);
    logic [3:0] v, l, acc;
    for (int i = 0; i < NR; i++) begin
      req_data[i*DW +: DW] = bw(i, p_pkt[i], p_idx[i]);
      v[i] = (p_act[i] != 0) && en[i];
      l[i] = (p_idx[i] == p_len[i] - 1);
    end
    step(r, v, l, fn, acc);
    if (!r) for (int i = 0; i < NR; i++) if (acc[i]) pop(i);
  endtask

  task automatic do_reset();
    for (int i = 0; i < NR; i++) setup(i, 0, 1);
    pstep(1'b1, 4'h0, 1'b1);
    pstep(1'b1, 4'h0, 1'b1);
    wlog.delete();
    expq.delete();
  endtask

  task automatic cmp_log(input string nm);
    int n;
    chk({nm, "_len"}, 64'(wlog.size()), 64'(expq.size()));
    n = (wlog.size() < expq.size()) ? wlog.size() : expq.size();
    for (int k = 0; k < n; k++) chk($sformatf("%s_beat%0d", nm, k), wlog[k], expq[k]);
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] v;
    logic [3:0] l;
    logic       fn;
    logic       busy;
    logic [1:0] g;
    logic [3:0] rdy;
    logic       wr;
  } vec_t;

  vec_t tv [19];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] acc;
    //          rst   v      l      fn    busy  g     rdy    wr
    tv[0]  = '{1'b1, 4'hF, 4'hF, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0};
    tv[1]  = '{1'b1, 4'hF, 4'hF, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0};
    tv[2]  = '{1'b0, 4'hF, 4'hF, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0};
    tv[3]  = '{1'b0, 4'hF, 4'hF, 1'b1, 1'b1, 2'd0, 4'h1, 1'b1};
    tv[4]  = '{1'b0, 4'hF, 4'hF, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0};
    tv[5]  = '{1'b0, 4'hF, 4'hF, 1'b1, 1'b1, 2'd1, 4'h2, 1'b1};
    tv[6]  = '{1'b0, 4'hF, 4'hF, 1'b1, 1'b0, 2'd1, 4'h0, 1'b0};
    tv[7]  = '{1'b0, 4'hF, 4'hF, 1'b1, 1'b1, 2'd2, 4'h4, 1'b1};
    tv[8]  = '{1'b0, 4'hF, 4'hF, 1'b1, 1'b0, 2'd2, 4'h0, 1'b0};
    tv[9]  = '{1'b0, 4'hF, 4'hF, 1'b1, 1'b1, 2'd3, 4'h8, 1'b1};
    tv[10] = '{1'b0, 4'hF, 4'hF, 1'b1, 1'b0, 2'd3, 4'h0, 1'b0};
    tv[11] = '{1'b0, 4'hF, 4'hF, 1'b1, 1'b1, 2'd0, 4'h1, 1'b1};
    tv[12] = '{1'b0, 4'h4, 4'h0, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0};
    tv[13] = '{1'b0, 4'h4, 4'h0, 1'b0, 1'b1, 2'd2, 4'h0, 1'b0};
    tv[14] = '{1'b0, 4'h4, 4'h0, 1'b1, 1'b1, 2'd2, 4'h4, 1'b1};
    tv[15] = '{1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 2'd2, 4'h4, 1'b0};
    tv[16] = '{1'b0, 4'hF, 4'h4, 1'b1, 1'b1, 2'd2, 4'h4, 1'b1};
    tv[17] = '{1'b0, 4'h3, 4'h0, 1'b1, 1'b0, 2'd2, 4'h0, 1'b0};
    tv[18] = '{1'b0, 4'h3, 4'h0, 1'b1, 1'b1, 2'd0, 4'h1, 1'b1};

    for (int i = 0; i < NR; i++) setup(i, 0, 1);
    @(negedge clk);
    pstep(1'b1, 4'h0, 1'b1);
    m_on = 1'b1;

    // Vector table: reset hold, round-robin rotation, stall, gap, last handling.
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = tword(i);
    for (int k = 0; k < 19; k++) begin
      step(tv[k].rst, tv[k].v, tv[k].l, tv[k].fn, acc);
      chk($sformatf("tbl%0d_busy", k),  64'(s_busy),  64'(tv[k].busy));
      chk($sformatf("tbl%0d_grant", k), 64'(s_grant), 64'(tv[k].g));
      chk($sformatf("tbl%0d_ready", k), 64'(s_ready), 64'(tv[k].rdy));
      chk($sformatf("tbl%0d_write", k), 64'(s_write), 64'(tv[k].wr));
      if (tv[k].wr) chk($sformatf("tbl%0d_din", k), s_din, tword(int'(tv[k].g)));
    end

    // Backpressure: requester 2, 5 beats, FIFO full for 3 cycles mid-packet.
    do_reset();
    setup(2, 1, 5);
    for (int c = 0; c < 15; c++) begin
      pstep(1'b0, 4'hF, !(c >= 4 && c <= 6));
      if (c >= 4 && c <= 6) chk("bp_ready_stall", 64'(s_ready[2]), 64'd0);
    end
    for (int b = 0; b < 5; b++) expq.push_back(bw(2, 0, b));
    cmp_log("bp");

    // Burst limit: r0 10-beat packet competing with r1 3-beat packet.
    do_reset();
    setup(0, 1, 10);
    setup(1, 1, 3);
    for (int c = 0; c < 40; c++) pstep(1'b0, 4'hF, 1'b1);
`ifdef PP_ARB_BURST_LIMIT_EN
    for (int b = 0; b < 4; b++)  expq.push_back(bw(0, 0, b));
    for (int b = 0; b < 3; b++)  expq.push_back(bw(1, 0, b));
    for (int b = 4; b < 10; b++) expq.push_back(bw(0, 0, b));
`else
    for (int b = 0; b < 10; b++) expq.push_back(bw(0, 0, b));
    for (int b = 0; b < 3; b++)  expq.push_back(bw(1, 0, b));
`endif
    cmp_log("burst");

    // Mid-packet gap: r0 drops valid for 6 cycles while r1/r2 wait.
    do_reset();
    for (int i = 0; i < 3; i++) setup(i, 1, 4);
    for (int c = 0; c < 35; c++) begin
      pstep(1'b0, (c >= 3 && c <= 8) ? 4'b1110 : 4'b1111, 1'b1);
      if (c >= 3 && c <= 8) begin
        chk("gap_no_write", 64'(s_write), 64'd0);
        chk("gap_hold_grant", 64'(s_grant), 64'd0);
      end
    end
    for (int i = 0; i < 3; i++) for (int b = 0; b < 4; b++) expq.push_back(bw(i, 0, b));
    cmp_log("gap");

    // Reset after beat 2 of an 8-beat packet from r3.
    do_reset();
    setup(3, 1, 8);
    for (int c = 0; c < 3; c++) pstep(1'b0, 4'hF, 1'b1);
    chk("rst_mid_pre_busy", 64'(s_busy), 64'd1);
    pstep(1'b1, 4'hF, 1'b1);
    for (int i = 0; i < NR; i++) setup(i, 1, 2);
    pstep(1'b0, 4'hF, 1'b1);
    chk("rst_mid_busy", 64'(s_busy), 64'd0);
    chk("rst_mid_write", 64'(s_write), 64'd0);
    pstep(1'b0, 4'hF, 1'b1);
    chk("rst_mid_regrant", 64'(s_grant), 64'd0);
    chk("rst_mid_busy2", 64'(s_busy), 64'd1);

    // Randomized traffic against the reference model.
    do_reset();
    for (int i = 0; i < NR; i++) setup(i, -1, 0);
    for (int c = 0; c < 800; c++) begin
      logic [3:0] en;
      for (int i = 0; i < NR; i++) en[i] = ($urandom_range(0, 4) != 0);
      pstep(1'b0, en, $urandom_range(0, 3) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pp_pipeline_accel_fifo_wr_arb.md
# pp_pipeline_accel_fifo_wr_arb

Round-robin write arbiter that shares one `pp_pipeline_accel` shift-register stream FIFO write port among `NUM_REQ` producer streams. It sits between the producer stages of the preprocessing pipeline and the FIFO's `if_write`/`if_din`/`if_full_n` port. A granted requester keeps the port for a whole packet, so packets are never interleaved in the FIFO. An optional burst limit forces release so that no single requester can starve the others.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `DATA_WIDTH`, default 64: beat width; must match the FIFO's `DATA_WIDTH`.
- `MAX_BURST`, default 16: beat limit per grant, 1..255. Used only with `PP_ARB_BURST_LIMIT_EN`.

Ports:
- `clk`  in  1: clock.
- `reset`  in  1: synchronous, active-high.
- `req_valid`  in  NUM_REQ: per-requester beat valid.
- `req_data`  in  NUM_REQ*DATA_WIDTH: requester i occupies bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `req_last`  in  NUM_REQ: the current beat is the last of its packet.
- `req_ready`  out  NUM_REQ: the beat is accepted this cycle when valid & ready.
- `fifo_write`  out  1: drives the FIFO `if_write`; `if_write_ce` is tied high.
- `fifo_din`  out  DATA_WIDTH: drives the FIFO `if_din`.
- `fifo_full_n`  in  1: from the FIFO `if_full_n`.
- `grant_id`  out  clog2(NUM_REQ): currently granted requester.
- `busy`  out  1: high while in BURST.

## Operation
- FSM has two states, IDLE and BURST. Registers: `state`, `grant_id`, `rr_ptr` (the last granted requester) and, if enabled, `beat_cnt`.
- **IDLE:**
  - If any `req_valid` is high, pick the first valid requester searching from `rr_ptr+1` upward with wrap-around.
  - Register the winner into `grant_id` and go to BURST.
  - `req_ready` = 0 and `fifo_write` = 0 in IDLE.
- **BURST:**
  - `req_ready[grant_id]` = `fifo_full_n`; all other `req_ready` bits are 0.
  - `fifo_write` = `req_valid[grant_id] & fifo_full_n`.
  - `fifo_din` = the `req_data` slice of `grant_id`; its value is don't-care when `fifo_write` is 0.
  - A beat is defined as `fifo_write` = 1.
- **End of burst:** on a beat with `req_last[grant_id]` = 1, or on the `MAX_BURST`-th beat when the limit is enabled.
  - The FSM returns to IDLE, `rr_ptr` ← `grant_id`, and `beat_cnt` ← 0.
- **Deasserted valid:** if the granted requester drops `req_valid` mid-packet, the grant is held indefinitely and no beats are issued. This is not an error.
- **Full FIFO:** when `fifo_full_n` = 0, the arbiter stalls with state and counters unchanged.
- **Valid bits:** `req_valid` bits of non-granted requesters are ignored during BURST.
- **Arithmetic:**
  - `beat_cnt` is clog2(MAX_BURST+1) bits wide and increments on each beat.
  - `rr_ptr` wraps from `NUM_REQ-1` to 0.

## Timing
- **Reset values:**
  - state = IDLE, `rr_ptr` = `NUM_REQ-1` (requester 0 has priority first), `grant_id` = 0, `beat_cnt` = 0.
  - `busy` = 0, `fifo_write` = 0, `req_ready` = 0.
- **Grant latency:** `req_valid` sampled in IDLE at edge N gives `busy` = 1 and `req_ready` for the winner in cycle N+1. The first beat can occur in cycle N+1.
- **Bus turnaround:** the final beat in cycle M gives IDLE in cycle M+1. The earliest next burst starts in cycle M+2, so there is exactly one bubble cycle between bursts.
- **Combinational paths:** `fifo_write` and `req_ready` depend combinationally on `fifo_full_n` and `req_valid`. No registered output stage is added; the FIFO registers the data.
- **Simultaneous requests:** when all requesters are valid continuously with single-beat packets, grants rotate 0,1,2,3,0…
- **Reset mid-burst:** the FSM returns to IDLE on the next edge and the partial packet is abandoned. The FIFO is reset together with the arbiter by the same `reset`.

## Configuration
- **`PP_ARB_BURST_LIMIT_EN` defined:**
  - `beat_cnt` is instantiated.
  - A burst ends at `req_last` or at `MAX_BURST` beats, whichever comes first.
  - After a forced release, the rest of the packet re-arbitrates like a new request. Its beats may follow another requester's data.
- **Not defined:**
  - No counter exists and `MAX_BURST` is unused.
  - A burst ends only on `req_last`, so packets are never split.

## Test plan
- **Reset:** assert reset with all requesters valid -> `busy` = 0, `fifo_write` = 0 and `req_ready` = 0 throughout. First grant after release goes to requester 0.
- **Round-robin fairness:** all 4 requesters send continuous single-beat packets with `fifo_full_n` = 1 -> `grant_id` sequence is 0,1,2,3,0,1. Each beat is followed by one bubble cycle.
- **Backpressure:** requester 2 sends a 5-beat packet while `fifo_full_n` drops for 3 cycles mid-packet -> the FIFO receives exactly 5 writes, in order, with no beats from other requesters. `req_ready[2]` is 0 during the stall.
- **Burst limit (`PP_ARB_BURST_LIMIT_EN`, `MAX_BURST`=4):** requester 0 sends a 10-beat packet while requester 1 is valid -> the write order is 4 beats from r0, then r1's packet, then 4 beats from r0, and so on. Without the macro, all 10 r0 beats are written contiguously.
- **Mid-packet gap:** the granted requester drops `req_valid` for 6 cycles mid-packet while the others are valid -> the grant is held, there are no writes, and the packet resumes afterwards.
- **Reset mid-burst:** reset is asserted after beat 2 of 8 -> `busy` = 0 on the next cycle. After release, arbitration restarts from requester 0.
